// File: rtl/dtw_score_collector_pkg.sv
// Shared types and constants for the DTW final-row score collector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dtw_score_collector_pkg;

   // Collector control states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESULT  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_IDX_W = 16;

   // All-ones "no match yet" cost; sliced down to the instance cost width
   localparam int                    MAX_COST_W = 64;
   localparam logic [MAX_COST_W-1:0] COST_MAX   = '1;

endpackage

// File: rtl/dtw_sat_counter.sv
// Saturating up-counter giving both the sample count and the current column index.
// Latency: value updates one clk after inc/clr; clr takes priority over inc.
// Backpressure: none; sticks at all-ones instead of wrapping.
module dtw_sat_counter
   import dtw_score_collector_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [IDX_W-1:0] value
);

   localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

   // Clear on a new query, otherwise count up until all ones and hold there
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && !(&value)) begin
         value <= value + ONE;
      end
   end

endmodule

// File: rtl/dtw_score_collector.sv
// Tracks the minimum final-row DTW cost and its column over one query, then presents it.
// Latency: result valid one clk after the sample carrying s_last is accepted.
// Backpressure: s_ready only in COLLECT; result held stable in RESULT until m_ready.
module dtw_score_collector
   import dtw_score_collector_pkg::*;
#(
   parameter int width = DEF_WIDTH,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [width-1:0] s_cost,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [width-1:0] m_cost,
   output logic [IDX_W-1:0] m_idx,
   output logic [IDX_W-1:0] m_count,
   output logic             busy
);

   localparam logic [width-1:0] MAX = COST_MAX[width-1:0];

   state_t           state;
   state_t           next_state;
   logic             arm;
   logic             take;
   logic [width-1:0] min_cost;
   logic [IDX_W-1:0] min_idx;
   logic [IDX_W-1:0] count;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and handshake outputs; start is only honoured from IDLE
   always_comb begin
      next_state = state;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      busy       = 1'b1;
      arm        = 1'b0;
      take       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = COLLECT;
               arm        = 1'b1;
            end
         end
         COLLECT: begin
            s_ready = 1'b1;
            take    = s_valid;
            if (s_valid && s_last) begin
               next_state = RESULT;
            end
         end
         RESULT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Running minimum; strict compare so ties keep the earlier column
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_cost <= MAX;
         min_idx  <= '0;
      end else if (arm) begin
         min_cost <= MAX;
         min_idx  <= '0;
      end else if (take && (s_cost < min_cost)) begin
         min_cost <= s_cost;
         min_idx  <= count;
      end
   end

   // Count doubles as the column index of the sample being accepted
   dtw_sat_counter #(
      .IDX_W (IDX_W)
   ) u_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (arm),
      .inc   (take),
      .value (count)
   );

   assign m_cost  = min_cost;
   assign m_idx   = min_idx;
   assign m_count = count;

endmodule

// File: tb/tb_dtw_score_collector.sv
// Bench for dtw_score_collector: a 16-bit-index instance and a 4-bit-index instance share stimulus.
// Latency: expected results queued when a query is driven, popped when m_valid is seen.
// Backpressure: m_ready driven per scenario; every wait on the DUT is cycle-bounded.
module tb_dtw_score_collector;
   import dtw_score_collector_pkg::*;

   typedef struct {
      logic [15:0] cost;
      logic [15:0] idx;
      logic [15:0] cnt;
      logic [3:0]  idx4;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] stim[$];
   int          asserts = 0;
   int          fails   = 0;

   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic        start   = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_last  = 1'b0;
   logic        m_ready = 1'b0;
   logic [15:0] s_cost  = 16'd0;

   logic        a_s_ready, a_m_valid, a_busy;
   logic [15:0] a_m_cost, a_m_idx, a_m_count;
   logic        b_s_ready, b_m_valid, b_busy;
   logic [15:0] b_m_cost;
   logic [3:0]  b_m_idx, b_m_count;

   always #5 clk = ~clk;

   dtw_score_collector dut_a (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(a_s_ready),
      .s_cost(s_cost), .s_last(s_last), .m_valid(a_m_valid), .m_ready(m_ready),
      .m_cost(a_m_cost), .m_idx(a_m_idx), .m_count(a_m_count), .busy(a_busy)
   );

   dtw_score_collector #(.width(16), .IDX_W(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(b_s_ready),
      .s_cost(s_cost), .s_last(s_last), .m_valid(b_m_valid), .m_ready(m_ready),
      .m_cost(b_m_cost), .m_idx(b_m_idx), .m_count(b_m_count), .busy(b_busy)
   );

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive stim[] as one query; the model queues the expected result when s_last is used
   task automatic send_query(input bit with_last, input bit gaps);
      logic [15:0] mn;
      logic [15:0] ix;
      logic [3:0]  ix4;
      int          n;
      int          w;
      exp_t        e;
      mn  = 16'hFFFF;
      ix  = 16'd0;
      ix4 = 4'd0;
      n   = stim.size();
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            s_cost = 16'd0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         s_valid = 1'b1;
         s_cost  = stim[i];
         s_last  = with_last && (i == n - 1);
         w = 0;
         while (a_s_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         asserts++;
         if (w >= 20) begin
            fails++;
            $display("FAIL send_ready: s_ready=%b after %0d cycles, required 1", a_s_ready, w);
         end
         @(negedge clk);
         s_valid = 1'b0;
         s_last  = 1'b0;
         if (stim[i] < mn) begin
            mn  = stim[i];
            ix  = i[15:0];
            ix4 = (i > 15) ? 4'd15 : i[3:0];
         end
      end
      if (with_last) begin
         e.cost = mn;
         e.idx  = ix;
         e.cnt  = n[15:0];
         e.idx4 = ix4;
         e.cnt4 = (n > 15) ? 4'd15 : n[3:0];
         sb.push_back(e);
      end
      stim.delete();
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (a_m_valid !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      asserts++;
      if (a_m_valid !== 1'b0 || a_s_ready !== 1'b0 || a_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: m_valid=%b s_ready=%b busy=%b, required 0 0 0", a_m_valid, a_s_ready, a_busy);
      end
      asserts++;
      if (a_m_cost !== 16'hFFFF || a_m_idx !== 16'd0 || a_m_count !== 16'd0) begin
         fails++;
         $display("FAIL reset_data: cost=%h idx=%0d count=%0d, required ffff 0 0", a_m_cost, a_m_idx, a_m_count);
      end
      asserts++;
      if (b_m_cost !== 16'hFFFF || b_m_idx !== 4'd0 || b_m_count !== 4'd0 || b_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_b: cost=%h idx=%0d count=%0d busy=%b, required ffff 0 0 0", b_m_cost, b_m_idx, b_m_count, b_busy);
      end
      rst = 1'b1;
      s_valid = 1'b1;
      s_last  = 1'b1;
      s_cost  = 16'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         asserts++;
         if (a_s_ready !== 1'b0 || a_busy !== 1'b0 || a_m_valid !== 1'b0 || a_m_count !== 16'd0 || a_m_cost !== 16'hFFFF) begin
            fails++;
            $display("FAIL idle_ignore: s_ready=%b busy=%b m_valid=%b count=%0d cost=%h, required 0 0 0 0 ffff",
                     a_s_ready, a_busy, a_m_valid, a_m_count, a_m_cost);
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic test_basic();
      exp_t        e;
      int          cyc;
      logic [15:0] c [4] = '{16'd40, 16'd12, 16'd30, 16'd12};
      m_ready = 1'b1;
      pulse_start();
      foreach (c[i]) stim.push_back(c[i]);
      send_query(1'b1, 1'b0);
      asserts++;
      if (a_m_valid !== 1'b1) begin
         fails++;
         $display("FAIL basic_latency: m_valid=%b one cycle after last, required 1", a_m_valid);
      end
      wait_result(cyc);
      e = sb.pop_front();
      asserts++;
      if (a_m_cost !== e.cost || a_m_idx !== e.idx || a_m_count !== e.cnt) begin
         fails++;
         $display("FAIL basic_result: cost=%0d idx=%0d count=%0d, required %0d %0d %0d",
                  a_m_cost, a_m_idx, a_m_count, e.cost, e.idx, e.cnt);
      end
      @(negedge clk);
      asserts++;
      if (a_busy !== 1'b0 || a_m_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_handshake: busy=%b m_valid=%b after accept, required 0 0", a_busy, a_m_valid);
      end
   endtask

   task automatic test_no_match();
      exp_t e;
      int   cyc;
      m_ready = 1'b1;
      pulse_start();
      stim.push_back(16'hFFFF);
      send_query(1'b1, 1'b0);
      wait_result(cyc);
      e = sb.pop_front();
      asserts++;
      if (cyc >= 20 || a_m_cost !== e.cost || a_m_idx !== e.idx || a_m_count !== e.cnt) begin
         fails++;
         $display("FAIL no_match: waited=%0d cost=%h idx=%0d count=%0d, required %h %0d %0d",
                  cyc, a_m_cost, a_m_idx, a_m_count, e.cost, e.idx, e.cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      exp_t        e;
      int          cyc;
      logic [15:0] c [3] = '{16'd5, 16'd2, 16'd9};
      m_ready = 1'b0;
      pulse_start();
      foreach (c[i]) stim.push_back(c[i]);
      send_query(1'b1, 1'b0);
      wait_result(cyc);
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_last  = 1'b1;
         s_cost  = 16'd0;
         start   = (k % 2 == 0);
         asserts++;
         if (a_s_ready !== 1'b0 || a_m_valid !== 1'b1 || a_m_cost !== e.cost || a_m_idx !== e.idx || a_m_count !== e.cnt) begin
            fails++;
            $display("FAIL bp_hold: s_ready=%b m_valid=%b cost=%0d idx=%0d count=%0d, required 0 1 %0d %0d %0d",
                     a_s_ready, a_m_valid, a_m_cost, a_m_idx, a_m_count, e.cost, e.idx, e.cnt);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      asserts++;
      if (a_busy !== 1'b0 || a_m_valid !== 1'b0 || a_s_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_accept: busy=%b m_valid=%b s_ready=%b, required 0 0 0", a_busy, a_m_valid, a_s_ready);
      end
      @(negedge clk);
      asserts++;
      if (a_busy !== 1'b0 || a_m_cost !== e.cost) begin
         fails++;
         $display("FAIL bp_start_ignored: busy=%b cost=%0d, required 0 %0d", a_busy, a_m_cost, e.cost);
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      int   cyc;
      m_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 20; i++) stim.push_back(16'(100 - i));
      send_query(1'b1, 1'b0);
      wait_result(cyc);
      e = sb.pop_front();
      asserts++;
      if (b_m_valid !== 1'b1 || b_m_cost !== e.cost || b_m_idx !== e.idx4 || b_m_count !== e.cnt4) begin
         fails++;
         $display("FAIL sat_idx4: m_valid=%b cost=%0d idx=%0d count=%0d, required 1 %0d %0d %0d",
                  b_m_valid, b_m_cost, b_m_idx, b_m_count, e.cost, e.idx4, e.cnt4);
      end
      asserts++;
      if (a_m_cost !== e.cost || a_m_idx !== e.idx || a_m_count !== e.cnt) begin
         fails++;
         $display("FAIL sat_idx16: cost=%0d idx=%0d count=%0d, required %0d %0d %0d",
                  a_m_cost, a_m_idx, a_m_count, e.cost, e.idx, e.cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      int          cyc;
      logic [15:0] c [3] = '{16'd70, 16'd60, 16'd65};
      m_ready = 1'b1;
      pulse_start();
      foreach (c[i]) stim.push_back(c[i]);
      send_query(1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      asserts++;
      if (a_busy !== 1'b0 || a_s_ready !== 1'b0 || a_m_valid !== 1'b0 || a_m_cost !== 16'hFFFF || a_m_count !== 16'd0) begin
         fails++;
         $display("FAIL rst_collect: busy=%b s_ready=%b m_valid=%b cost=%h count=%0d, required 0 0 0 ffff 0",
                  a_busy, a_s_ready, a_m_valid, a_m_cost, a_m_count);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         asserts++;
         if (a_m_valid !== 1'b0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_emit: m_valid=%b busy=%b, required 0 0", a_m_valid, a_busy);
         end
      end
      // pending result discarded by reset
      m_ready = 1'b0;
      pulse_start();
      stim.push_back(16'd8);
      send_query(1'b1, 1'b0);
      e = sb.pop_front();
      #2 rst = 1'b0;
      #1;
      asserts++;
      if (a_m_valid !== 1'b0 || a_m_cost !== 16'hFFFF || a_m_idx !== 16'd0) begin
         fails++;
         $display("FAIL rst_result: m_valid=%b cost=%h idx=%0d (pending %0d), required 0 ffff 0",
                  a_m_valid, a_m_cost, a_m_idx, e.cost);
      end
      @(negedge clk);
      rst = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      pulse_start();
      stim.push_back(16'd50);
      stim.push_back(16'd60);
      send_query(1'b1, 1'b0);
      wait_result(cyc);
      e = sb.pop_front();
      asserts++;
      if (cyc >= 20 || a_m_cost !== e.cost || a_m_idx !== e.idx || a_m_count !== e.cnt) begin
         fails++;
         $display("FAIL rst_next_query: waited=%0d cost=%0d idx=%0d count=%0d, required %0d %0d %0d",
                  cyc, a_m_cost, a_m_idx, a_m_count, e.cost, e.idx, e.cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_random_valid();
      exp_t        e;
      int          cyc;
      logic [15:0] c [8] = '{16'd9, 16'd7, 16'd7, 16'd3, 16'd5, 16'd3, 16'd8, 16'd4};
      m_ready = 1'b1;
      pulse_start();
      foreach (c[i]) stim.push_back(c[i]);
      send_query(1'b1, 1'b1);
      wait_result(cyc);
      e = sb.pop_front();
      asserts++;
      if (cyc >= 20 || a_m_cost !== e.cost || a_m_idx !== e.idx || a_m_count !== e.cnt) begin
         fails++;
         $display("FAIL random_valid: waited=%0d cost=%0d idx=%0d count=%0d, required %0d %0d %0d",
                  cyc, a_m_cost, a_m_idx, a_m_count, e.cost, e.idx, e.cnt);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog timeout");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_no_match();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      test_random_valid();
      asserts++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d results left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
